// File: rtl/idu_pkg.sv
// idu_pkg: shared RV32I opcode, class and ALU-op encodings for the decode stage.
// Also carries the immediate-format selector used by idu_imm_gen.
package idu_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    CLS_R_ALU  = 3'd0,
    CLS_I_ALU  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JUMP   = 3'd5,
    CLS_UPPER  = 3'd6,
    CLS_SYSTEM = 3'd7
  } cls_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(
    input logic [6:0] opc
  );
    imm_fmt_e f;
    f = IMM_R;
    unique case (opc)
      OP_IMM, LOAD,
      JALR, SYSTEM: f = IMM_I;
      STORE:        f = IMM_S;
      BRANCH:       f = IMM_B;
      LUI, AUIPC:   f = IMM_U;
      JAL:          f = IMM_J;
      default:      f = IMM_R;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// idu_imm_gen: combinational RV32I immediate generator.
// Every format is sign-extended from instruction bit 31.
module idu_imm_gen
  import idu_pkg::*;
#(
  parameter int ISA_WIDTH = 32
) (
  input  logic [ISA_WIDTH-1:0] ins,
  output logic [ISA_WIDTH-1:0] imm
);

  imm_fmt_e    fmt;
  logic [31:0] imm32;

  assign fmt = imm_fmt(ins[6:0]);

  always_comb begin
    imm32 = '0;
    unique case (fmt)
      IMM_I: imm32 = {{20{ins[31]}},
                      ins[31:20]};
      IMM_S: imm32 = {{20{ins[31]}},
                      ins[31:25],
                      ins[11:7]};
      IMM_B: imm32 = {{19{ins[31]}},
                      ins[31], ins[7],
                      ins[30:25],
                      ins[11:8], 1'b0};
      IMM_U: imm32 = {ins[31:12],
                      12'b0};
      IMM_J: imm32 = {{11{ins[31]}},
                      ins[31],
                      ins[19:12],
                      ins[20],
                      ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = ISA_WIDTH'($signed(imm32));

endmodule

// File: rtl/idu_stage.sv
// idu_stage: RV32I decode stage between fetch and execute (valid/ready both sides).
// Define IDU_SKID_BUF_EN for a second skid entry with a registered o_pre_ready.
module idu_stage
  import idu_pkg::*;
#(
  parameter int ISA_WIDTH = 32,
  parameter int REG_AW    = 5
) (
  input  logic                 clk,
  input  logic                 ifu_rst,
  input  logic [ISA_WIDTH-1:0] i_ins,
  input  logic [ISA_WIDTH-1:0] i_pc,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic                 i_post_ready,
  output logic                 o_post_valid,
  input  logic                 i_flush,
  output logic [ISA_WIDTH-1:0] o_pc,
  output logic [ISA_WIDTH-1:0] o_ins,
  output logic [REG_AW-1:0]    o_rs1,
  output logic [REG_AW-1:0]    o_rs2,
  output logic [REG_AW-1:0]    o_rd,
  output logic [ISA_WIDTH-1:0] o_imm,
  output logic [2:0]           o_cls,
  output logic [3:0]           o_alu_op,
  output logic                 o_rf_wen,
  output logic                 o_illegal
);

  logic                 vld;
  logic [ISA_WIDTH-1:0] ins_q;
  logic [ISA_WIDTH-1:0] pc_q;
  logic                 acc;

  assign acc = i_pre_valid & o_pre_ready;

`ifdef IDU_SKID_BUF_EN
  logic                 skd_vld;
  logic [ISA_WIDTH-1:0] skd_ins;
  logic [ISA_WIDTH-1:0] skd_pc;
  logic                 adv;

  assign o_pre_ready = ~skd_vld;
  assign adv         = ~vld | i_post_ready;

  always_ff @(posedge clk or negedge ifu_rst) begin
    if (!ifu_rst) begin
      vld     <= 1'b0;
      ins_q   <= '0;
      pc_q    <= '0;
      skd_vld <= 1'b0;
      skd_ins <= '0;
      skd_pc  <= '0;
    end else if (i_flush) begin
      vld     <= 1'b0;
      skd_vld <= 1'b0;
    end else if (adv) begin
      // skid entry is older than anything arriving now
      if (skd_vld) begin
        vld     <= 1'b1;
        ins_q   <= skd_ins;
        pc_q    <= skd_pc;
        skd_vld <= 1'b0;
      end else if (acc) begin
        vld   <= 1'b1;
        ins_q <= i_ins;
        pc_q  <= i_pc;
      end else begin
        vld <= 1'b0;
      end
    end else if (acc) begin
      skd_vld <= 1'b1;
      skd_ins <= i_ins;
      skd_pc  <= i_pc;
    end
  end
`else
  assign o_pre_ready = ~vld | i_post_ready;

  always_ff @(posedge clk or negedge ifu_rst) begin
    if (!ifu_rst) begin
      vld   <= 1'b0;
      ins_q <= '0;
      pc_q  <= '0;
    end else if (i_flush) begin
      vld <= 1'b0;
    end else if (acc) begin
      vld   <= 1'b1;
      ins_q <= i_ins;
      pc_q  <= i_pc;
    end else if (i_post_ready) begin
      vld <= 1'b0;
    end
  end
`endif

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  cls_e       cls;
  logic       ill;
  logic       wen;
  logic       alt;

  assign opc = ins_q[6:0];
  assign f3  = ins_q[14:12];
  assign f7  = ins_q[31:25];

  always_comb begin
    cls = CLS_R_ALU;
    ill = 1'b0;
    wen = 1'b0;
    alt = 1'b0;
    unique case (1'b1)
      (opc == OP): begin
        cls = CLS_R_ALU;
        wen = 1'b1;
        alt = f7[5];
        if (f7 != 7'h00 && f7 != 7'h20)
          ill = 1'b1;
        if (f7 == 7'h20 && f3 != 3'b000
            && f3 != 3'b101)
          ill = 1'b1;
      end
      (opc == OP_IMM): begin
        cls = CLS_I_ALU;
        wen = 1'b1;
        if (f3 == 3'b001)
          ill = (f7 != 7'h00);
        if (f3 == 3'b101) begin
          alt = f7[5];
          ill = (f7 != 7'h00)
              && (f7 != 7'h20);
        end
      end
      (opc == LOAD): begin
        cls = CLS_LOAD;
        wen = 1'b1;
      end
      (opc == STORE):
        cls = CLS_STORE;
      (opc == BRANCH):
        cls = CLS_BRANCH;
      (opc == JAL) || (opc == JALR): begin
        cls = CLS_JUMP;
        wen = 1'b1;
      end
      (opc == LUI) || (opc == AUIPC): begin
        cls = CLS_UPPER;
        wen = 1'b1;
      end
      (opc == SYSTEM): begin
        cls = CLS_SYSTEM;
        wen = (f3 != 3'b000);
      end
      default:
        ill = 1'b1;
    endcase
    if (opc[1:0] != 2'b11)
      ill = 1'b1;
  end

  idu_imm_gen #(
    .ISA_WIDTH(ISA_WIDTH)
  ) u_imm (
    .ins(ins_q),
    .imm(o_imm)
  );

  assign o_post_valid = vld;
  assign o_pc         = pc_q;
  assign o_ins        = ins_q;
  assign o_rs1        = ins_q[15 +: REG_AW];
  assign o_rs2        = ins_q[20 +: REG_AW];
  assign o_rd         = ins_q[7 +: REG_AW];
  assign o_cls        = cls;
  assign o_alu_op     = {alt, f3};
  assign o_rf_wen     = wen & ~ill
                      & (ins_q[11:7] != 5'd0);
  // the zeroed reset word decodes as illegal; keep the flag quiet until a beat lands
  assign o_illegal    = ill & vld;

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: directed vectors into a scoreboard queue, checked by an output monitor.
// Stall, flush and reset behaviour are checked from the driver.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        ifu_rst = 1'b1;
  logic [31:0] i_ins = '0;
  logic [31:0] i_pc = '0;
  logic        i_pre_valid = 1'b0;
  logic        o_pre_ready;
  logic        i_post_ready = 1'b1;
  logic        o_post_valid;
  logic        i_flush = 1'b0;
  logic [31:0] o_pc;
  logic [31:0] o_ins;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic [4:0]  o_rd;
  logic [31:0] o_imm;
  logic [2:0]  o_cls;
  logic [3:0]  o_alu_op;
  logic        o_rf_wen;
  logic        o_illegal;

  idu_stage #(
    .ISA_WIDTH(32),
    .REG_AW(5)
  ) dut (
    .clk(clk),
    .ifu_rst(ifu_rst),
    .i_ins(i_ins),
    .i_pc(i_pc),
    .i_pre_valid(i_pre_valid),
    .o_pre_ready(o_pre_ready),
    .i_post_ready(i_post_ready),
    .o_post_valid(o_post_valid),
    .i_flush(i_flush),
    .o_pc(o_pc),
    .o_ins(o_ins),
    .o_rs1(o_rs1),
    .o_rs2(o_rs2),
    .o_rd(o_rd),
    .o_imm(o_imm),
    .o_cls(o_cls),
    .o_alu_op(o_alu_op),
    .o_rf_wen(o_rf_wen),
    .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  cls;
    logic [3:0]  alu;
    logic        wen;
    logic        ill;
  } exp_t;

  exp_t vec[$];
  exp_t sb[$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h",
               nm, got, exp);
    end
  endtask

  task automatic addv(input logic [31:0] ins,
                      input logic [4:0]  rs1,
                      input logic [4:0]  rs2,
                      input logic [4:0]  rd,
                      input logic [31:0] imm,
                      input logic [2:0]  cls,
                      input logic [3:0]  alu,
                      input logic        wen,
                      input logic        ill);
    exp_t e;
    e.id  = vec.size();
    e.ins = ins;
    e.pc  = 32'h0000_1000 + 32'(e.id * 4);
    e.imm = imm;
    e.rs1 = rs1;
    e.rs2 = rs2;
    e.rd  = rd;
    e.cls = cls;
    e.alu = alu;
    e.wen = wen;
    e.ill = ill;
    vec.push_back(e);
  endtask

  task automatic cyc(input logic v, input int idx,
                     input logic prdy, input logic fl,
                     output logic acc);
    @(negedge clk);
    i_pre_valid  = v;
    i_post_ready = prdy;
    i_flush      = fl;
    if (idx >= 0) begin
      i_ins = vec[idx].ins;
      i_pc  = vec[idx].pc;
    end
    #1;
    if (fl) sb.delete();
    acc = v && o_pre_ready && !fl;
    if (acc) sb.push_back(vec[idx]);
  endtask

  task automatic send(input int idx, input logic prdy);
    logic acc;
    int   n;
    n = 0;
    do begin
      cyc(1'b1, idx, prdy, 1'b0, acc);
      n++;
    end while (!acc && n < 20);
    chk($sformatf("v%0d accepted", idx), {31'b0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cyc(1'b0, -1, 1'b1, 1'b0, acc);
  endtask

  // monitor: pops the oldest expected beat on every output handshake
  always @(negedge clk) begin
    #2;
    if (ifu_rst && o_post_valid && i_post_ready && !i_flush) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected output: got ins %h, expected none", o_ins);
      end else begin
        me = sb.pop_front();
        chk($sformatf("v%0d pc", me.id), o_pc, me.pc);
        chk($sformatf("v%0d ins", me.id), o_ins, me.ins);
        chk($sformatf("v%0d rs1", me.id), 32'(o_rs1), 32'(me.rs1));
        chk($sformatf("v%0d rs2", me.id), 32'(o_rs2), 32'(me.rs2));
        chk($sformatf("v%0d rd", me.id), 32'(o_rd), 32'(me.rd));
        chk($sformatf("v%0d imm", me.id), o_imm, me.imm);
        chk($sformatf("v%0d cls", me.id), 32'(o_cls), 32'(me.cls));
        chk($sformatf("v%0d alu_op", me.id), 32'(o_alu_op), 32'(me.alu));
        chk($sformatf("v%0d rf_wen", me.id), 32'(o_rf_wen), 32'(me.wen));
        chk($sformatf("v%0d illegal", me.id), 32'(o_illegal), 32'(me.ill));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   idx;

    addv(32'h00500093, 0, 5, 1, 32'h5, 1, 4'h0, 1, 0);
    addv(32'hFE000EE3, 0, 0, 29, 32'hFFFFFFFC, 4, 4'h0, 0, 0);
    addv(32'h12345137, 8, 3, 2, 32'h12345000, 6, 4'h5, 1, 0);
    addv(32'h002081B3, 1, 2, 3, 32'h0, 0, 4'h0, 1, 0);
    addv(32'h40118233, 3, 1, 4, 32'h0, 0, 4'h8, 1, 0);
    addv(32'h4030D293, 1, 3, 5, 32'h403, 1, 4'hD, 1, 0);
    addv(32'h0020A423, 1, 2, 8, 32'h8, 3, 4'h2, 0, 0);
    addv(32'hFFC0A303, 1, 28, 6, 32'hFFFFFFFC, 2, 4'h2, 1, 0);
    addv(32'h008000EF, 0, 8, 1, 32'h8, 5, 4'h0, 1, 0);
    addv(32'h00208033, 1, 2, 0, 32'h0, 0, 4'h0, 0, 0);
    addv(32'h300093F3, 1, 0, 7, 32'h300, 7, 4'h1, 1, 0);
    addv(32'h00000073, 0, 0, 0, 32'h0, 7, 4'h0, 0, 0);
    addv(32'hFFFFFFFF, 31, 31, 31, 32'h0, 0, 4'h7, 0, 1);
    addv(32'h022081B3, 1, 2, 3, 32'h0, 0, 4'h0, 0, 1);
    addv(32'h402091B3, 1, 2, 3, 32'h0, 0, 4'h9, 0, 1);
    addv(32'h40109093, 1, 1, 1, 32'h401, 1, 4'h1, 0, 1);
    addv(32'h00500092, 0, 5, 1, 32'h0, 0, 4'h0, 0, 1);

    #1 ifu_rst = 1'b0;
    #2;
    chk("reset post_valid", 32'(o_post_valid), 32'd0);
    chk("reset pc", o_pc, 32'd0);
    chk("reset ins", o_ins, 32'd0);
    chk("reset imm", o_imm, 32'd0);
    chk("reset cls", 32'(o_cls), 32'd0);
    chk("reset alu_op", 32'(o_alu_op), 32'd0);
    chk("reset rf_wen", 32'(o_rf_wen), 32'd0);
    chk("reset illegal", 32'(o_illegal), 32'd0);
    @(negedge clk);
    ifu_rst = 1'b1;
    #1 chk("ready after reset", 32'(o_pre_ready), 32'd1);

    for (int i = 0; i <= 8; i++) send(i, 1'b1);
    idle(2);
    chk("idle post_valid", 32'(o_post_valid), 32'd0);

    send(9, 1'b0);
    idx = 10;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, idx, 1'b0, 1'b0, acc);
`ifdef IDU_SKID_BUF_EN
      chk($sformatf("stall%0d ready", k), 32'(o_pre_ready),
          (k == 0) ? 32'd1 : 32'd0);
`else
      chk($sformatf("stall%0d ready", k), 32'(o_pre_ready), 32'd0);
`endif
      chk($sformatf("stall%0d post_valid", k), 32'(o_post_valid), 32'd1);
      chk($sformatf("stall%0d ins held", k), o_ins, vec[9].ins);
      chk($sformatf("stall%0d rd held", k), 32'(o_rd), 32'd0);
      if (acc) idx++;
    end
    cyc(1'b1, idx, 1'b1, 1'b0, acc);
    if (acc) idx++;
    cyc(1'b0, -1, 1'b1, 1'b0, acc);
    chk("release post_valid", 32'(o_post_valid), 32'd1);
    chk("release next ins", o_ins, vec[10].ins);
    while (idx <= 11) begin
      send(idx, 1'b1);
      idx++;
    end
    idle(1);

    cyc(1'b1, 12, 1'b1, 1'b1, acc);
    cyc(1'b0, -1, 1'b1, 1'b0, acc);
    chk("flush on capture", 32'(o_post_valid), 32'd0);
    send(0, 1'b0);
    cyc(1'b0, -1, 1'b0, 1'b1, acc);
    cyc(1'b0, -1, 1'b1, 1'b0, acc);
    chk("flush on hold", 32'(o_post_valid), 32'd0);

    for (int i = 12; i <= 16; i++) send(i, 1'b1);
    idle(2);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    send(1, 1'b0);
    cyc(1'b0, -1, 1'b0, 1'b0, acc);
    chk("held before reset", 32'(o_post_valid), 32'd1);
    #2 ifu_rst = 1'b0;
    #1;
    chk("async reset post_valid", 32'(o_post_valid), 32'd0);
    chk("async reset ins", o_ins, 32'd0);
    sb.delete();
    @(negedge clk);
    ifu_rst = 1'b1;
    #1;
    chk("ready after mid reset", 32'(o_pre_ready), 32'd1);
    chk("valid after mid reset", 32'(o_post_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
